// File: rtl/apb_timer.sv
// APB completer for a 64-bit machine timer with prescaler, 64-bit compare and sticky PEND interrupt.
// Transfers complete WAIT_STATES cycles into the access phase (APB_pready low holds the initiator); reads are combinational.
module apb_timer #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic                  APB_PCLK,
   input  logic                  APB_PRESET,
   input  logic [ADDR_WIDTH-1:0] APB_paddr,
   input  logic [DATA_WIDTH-1:0] APB_pdata,
   output logic [DATA_WIDTH-1:0] APB_prdata,
   input  logic                  APB_psel,
   input  logic                  APB_penable,
   input  logic                  APB_pwrite,
   input  logic [3:0]            APB_pstb,
   output logic                  APB_pready,
   output logic                  APB_perr,
   output logic                  interrupt
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_e      state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d, wcnt_cur;
   logic [63:0] mtime_q, mtime_d, cmp_q, cmp_d;
   logic        en_q, en_d, irq_en_q, irq_en_d;
   logic [7:0]  presc_q, presc_d, pcnt_q, pcnt_d;
   logic        pend_q, pend_d, irq_q, irq_d;

   logic        access, done, addr_err, wr_en, tick, match, w1c;
   logic [2:0]  reg_idx;
   logic        unused_addr;

   assign unused_addr = ^APB_paddr[ADDR_WIDTH-1:5];

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdat,
                                         input logic [3:0] stb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = stb[i] ? wdat[8*i +: 8] : old[8*i +: 8];
      end
      return res;
   endfunction

   always_comb begin
      reg_idx  = APB_paddr[4:2];
      addr_err = (APB_paddr[1:0] != 2'b00) || (reg_idx > 3'd5);
      access   = APB_psel & APB_penable & ~APB_PRESET;
      // a fresh access phase (entered from IDLE/SETUP) always starts its wait count at zero
      wcnt_cur = (state_q == ACCESS) ? wcnt_q : 4'd0;
      done     = access & (wcnt_cur == WS);
      wr_en    = done & APB_pwrite & ~addr_err;
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      if (!APB_psel) begin
         state_d = IDLE;
         wcnt_d  = 4'd0;
      end else if (APB_penable) begin
         state_d = ACCESS;
         wcnt_d  = done ? 4'd0 : wcnt_cur + 4'd1;
      end else begin
         state_d = SETUP;
         wcnt_d  = 4'd0;
      end
   end

   always_comb begin
      tick     = en_q & (pcnt_q == presc_q);
      match    = en_q & (mtime_q >= cmp_q);
      pcnt_d   = pcnt_q;
      if (en_q) pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
      mtime_d  = tick ? mtime_q + 64'd1 : mtime_q;
      cmp_d    = cmp_q;
      en_d     = en_q;
      irq_en_d = irq_en_q;
      presc_d  = presc_q;
      w1c      = 1'b0;
      if (wr_en) begin
         // an MTIME write replaces the whole incremented value, so the tick is lost on both halves
         case (reg_idx)
            3'd0: mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], APB_pdata, APB_pstb)};
            3'd1: mtime_d = {merge(mtime_q[63:32], APB_pdata, APB_pstb), mtime_q[31:0]};
            3'd2: cmp_d   = {cmp_q[63:32], merge(cmp_q[31:0], APB_pdata, APB_pstb)};
            3'd3: cmp_d   = {merge(cmp_q[63:32], APB_pdata, APB_pstb), cmp_q[31:0]};
            3'd4: begin
               if (APB_pstb[0]) begin
                  en_d     = APB_pdata[0];
                  irq_en_d = APB_pdata[1];
               end
               if (APB_pstb[1]) presc_d = APB_pdata[15:8];
            end
            3'd5: w1c = APB_pstb[0] & APB_pdata[0];
            default: ;
         endcase
      end
      pend_d = match | (pend_q & ~w1c);
      irq_d  = irq_en_q & pend_q;
   end

   always_comb begin
      APB_prdata = '0;
      if (APB_psel && !APB_pwrite && !APB_PRESET && !addr_err) begin
         case (reg_idx)
            3'd0: APB_prdata = mtime_q[31:0];
            3'd1: APB_prdata = mtime_q[63:32];
            3'd2: APB_prdata = cmp_q[31:0];
            3'd3: APB_prdata = cmp_q[63:32];
            3'd4: APB_prdata = {16'h0, presc_q, 6'h0, irq_en_q, en_q};
            3'd5: APB_prdata = {31'h0, pend_q};
            default: APB_prdata = '0;
         endcase
      end
   end

   assign APB_pready = done;
   assign APB_perr   = done & addr_err;
   assign interrupt  = irq_q;

   always_ff @(posedge APB_PCLK) begin
      if (APB_PRESET) begin
         state_q  <= IDLE;
         wcnt_q   <= 4'd0;
         mtime_q  <= 64'd0;
         cmp_q    <= 64'd0;
         en_q     <= 1'b0;
         irq_en_q <= 1'b0;
         presc_q  <= 8'd0;
         pcnt_q   <= 8'd0;
         pend_q   <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         mtime_q  <= mtime_d;
         cmp_q    <= cmp_d;
         en_q     <= en_d;
         irq_en_q <= irq_en_d;
         presc_q  <= presc_d;
         pcnt_q   <= pcnt_d;
         pend_q   <= pend_d;
         irq_q    <= irq_d;
      end
   end

endmodule

// File: tb/tb_apb_timer.sv
// Bench for apb_timer: two instances (0 and 3 wait states), a register-level timer model and a per-cycle compare.
module tb_apb_timer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, psel, penable, pwrite, wsel;
   logic [31:0] paddr, pdata;
   logic [3:0]  pstb;
   logic        psel0, psel3;
   logic [31:0] prdata0, prdata3;
   logic        pready0, pready3, perr0, perr3, irq0, irq3;
   logic [31:0] a_prdata;
   logic        a_pready, a_perr, a_irq;

   assign psel0    = psel & ~wsel;
   assign psel3    = psel & wsel;
   assign a_prdata = wsel ? prdata3 : prdata0;
   assign a_pready = wsel ? pready3 : pready0;
   assign a_perr   = wsel ? perr3 : perr0;
   assign a_irq    = wsel ? irq3 : irq0;

   apb_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(0)) u_ws0 (
      .APB_PCLK(clk), .APB_PRESET(rst), .APB_paddr(paddr), .APB_pdata(pdata),
      .APB_prdata(prdata0), .APB_psel(psel0), .APB_penable(penable), .APB_pwrite(pwrite),
      .APB_pstb(pstb), .APB_pready(pready0), .APB_perr(perr0), .interrupt(irq0));

   apb_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(3)) u_ws3 (
      .APB_PCLK(clk), .APB_PRESET(rst), .APB_paddr(paddr), .APB_pdata(pdata),
      .APB_prdata(prdata3), .APB_psel(psel3), .APB_penable(penable), .APB_pwrite(pwrite),
      .APB_pstb(pstb), .APB_pready(pready3), .APB_perr(perr3), .interrupt(irq3));

   int errors = 0;
   int checks = 0;
   logic exp_done = 1'b0;
   logic exp_err  = 1'b0;
   logic chk_on   = 1'b0;

   logic [63:0] m_mtime, m_cmp, nxt_mtime;
   logic        m_en, m_irq_en, m_pend, m_irq, m_tick, m_match, m_w1c;
   logic [7:0]  m_presc, m_pcnt;

   function automatic logic is_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[4:0] >= 5'h18);
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      if (is_err(a)) return 32'h0;
      case (a[4:0])
         5'h00:   return m_mtime[31:0];
         5'h04:   return m_mtime[63:32];
         5'h08:   return m_cmp[31:0];
         5'h0C:   return m_cmp[63:32];
         5'h10:   return {16'h0, m_presc, 6'h0, m_irq_en, m_en};
         default: return {31'h0, m_pend};
      endcase
   endfunction

   function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Timer model: one step per clock, from the register map rules.
   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_mtime = 64'd0; m_cmp = 64'd0; m_en = 1'b0; m_irq_en = 1'b0;
         m_presc = 8'd0;  m_pcnt = 8'd0; m_pend = 1'b0; m_irq = 1'b0;
      end else begin
         m_tick    = m_en && (m_pcnt == m_presc);
         m_match   = m_en && (m_mtime >= m_cmp);
         m_w1c     = 1'b0;
         m_irq     = m_irq_en & m_pend;
         nxt_mtime = m_tick ? m_mtime + 64'd1 : m_mtime;
         if (m_tick) m_pcnt = 8'd0;
         else if (m_en) m_pcnt = m_pcnt + 8'd1;
         if (exp_done && pwrite && !exp_err) begin
            case (paddr[4:0])
               5'h00: nxt_mtime[31:0]  = bmerge(m_mtime[31:0], pdata, pstb);
               5'h04: nxt_mtime[63:32] = bmerge(m_mtime[63:32], pdata, pstb);
               5'h08: m_cmp[31:0]      = bmerge(m_cmp[31:0], pdata, pstb);
               5'h0C: m_cmp[63:32]     = bmerge(m_cmp[63:32], pdata, pstb);
               5'h10: begin
                  if (pstb[0]) begin m_en = pdata[0]; m_irq_en = pdata[1]; end
                  if (pstb[1]) m_presc = pdata[15:8];
               end
               default: m_w1c = pstb[0] & pdata[0];
            endcase
            if (exp_done && pwrite && !exp_err && paddr[4:2] <= 3'd1 && m_tick)
               nxt_mtime = (paddr[4:2] == 3'd0) ? {m_mtime[63:32], nxt_mtime[31:0]}
                                                : {nxt_mtime[63:32], m_mtime[31:0]};
         end
         m_pend  = m_match | (m_pend & ~m_w1c);
         m_mtime = nxt_mtime;
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         check("pready", {31'h0, a_pready}, {31'h0, exp_done});
         check("perr", {31'h0, a_perr}, {31'h0, exp_done & exp_err});
         check("prdata", a_prdata, (psel && !pwrite && !rst) ? m_read(paddr) : 32'h0);
         check("interrupt", {31'h0, a_irq}, {31'h0, m_irq});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      psel = 1'b0; penable = 1'b0; exp_done = 1'b0;
      repeat (n) step();
   endtask

   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic setup, output logic [31:0] rd);
      int ws;
      ws = wsel ? 3 : 0;
      rd = 32'h0;
      paddr = a; pdata = d; pwrite = wr; pstb = s; psel = 1'b1;
      if (setup) begin
         penable = 1'b0; exp_done = 1'b0;
         step();
      end
      penable = 1'b1;
      exp_err = is_err(a);
      for (int k = 0; k <= ws; k++) begin
         exp_done = (k == ws);
         if (k == ws) begin
            @(negedge clk);
            rd = a_prdata;
         end
         step();
      end
   endtask

   task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] dummy;
      xfer(1'b1, a, d, s, 1'b1, dummy);
      idle(1);
   endtask

   task automatic apb_rd(input logic [31:0] a, output logic [31:0] r);
      xfer(1'b0, a, 32'h0, 4'h0, 1'b1, r);
      idle(1);
   endtask

   task automatic do_reset();
      psel = 1'b0; penable = 1'b0; exp_done = 1'b0; rst = 1'b1;
      step(); step();
      rst = 1'b0;
   endtask

   logic [31:0] r;
   logic [31:0] rv [12];
   logic [31:0] exp_lo [12] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h1, 32'h1};

   initial begin
      rst = 1'b1; wsel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 32'h0; pdata = 32'h0; pstb = 4'h0;
      step();
      chk_on = 1'b1;
      step();
      rst = 1'b0;

      // reset state, single-cycle read
      apb_rd(32'h10, r);  check("ctrl_after_reset", r, 32'h0);
      apb_rd(32'h00, r);  check("mtime_after_reset", r, 32'h0);

      // compare at 0x10 with PRESC=0
      apb_wr(32'h08, 32'h0000_0010, 4'hF);
      apb_wr(32'h0C, 32'h0, 4'hF);
      apb_wr(32'h10, 32'h0000_0003, 4'hF);
      idle(14);
      apb_rd(32'h00, r);  check("mtime_16", r, 32'h10);
      apb_rd(32'h14, r);  check("pend_set", r, 32'h1);
      @(negedge clk);     check("irq_set", {31'h0, a_irq}, 32'h1);
      apb_wr(32'h14, 32'h1, 4'h1);
      apb_rd(32'h14, r);  check("pend_sticky_match", r, 32'h1);
      apb_wr(32'h0C, 32'h1, 4'hF);
      apb_wr(32'h14, 32'h1, 4'h1);
      apb_rd(32'h14, r);  check("pend_cleared", r, 32'h0);
      @(negedge clk);     check("irq_cleared", {31'h0, a_irq}, 32'h0);

      // PRESC=3 across the 64-bit wrap, back-to-back reads
      apb_wr(32'h10, 32'h0, 4'hF);
      apb_wr(32'h00, 32'hFFFF_FFFE, 4'hF);
      apb_wr(32'h04, 32'hFFFF_FFFF, 4'hF);
      apb_wr(32'h10, 32'h0000_0301, 4'hF);
      for (int i = 0; i < 12; i++) xfer(1'b0, 32'h00, 32'h0, 4'h0, (i == 0), rv[i]);
      idle(1);
      for (int i = 0; i < 12; i++) check($sformatf("presc_lo[%0d]", i), rv[i], exp_lo[i]);
      apb_rd(32'h04, r);  check("mtime_hi_wrapped", r, 32'h0);

      // byte strobes and write-vs-tick collision
      do_reset();
      apb_wr(32'h00, 32'hAABB_CCDD, 4'hF);
      apb_wr(32'h00, 32'h1234_5678, 4'b0100);
      apb_rd(32'h00, r);  check("pstb_byte2", r, 32'hAA34_CCDD);
      apb_wr(32'h10, 32'h0000_0001, 4'hF);
      apb_wr(32'h00, 32'h0000_0100, 4'hF);
      apb_rd(32'h00, r);  check("write_beats_tick", r, 32'h0000_0102);

      // error responses leave state untouched
      apb_wr(32'h10, 32'h0, 4'hF);
      apb_wr(32'h08, 32'h0000_0010, 4'hF);
      apb_wr(32'h0C, 32'h1, 4'hF);
      apb_rd(32'h18, r);  check("rd_unmapped", r, 32'h0);
      apb_rd(32'h1C, r);  check("rd_unmapped_1c", r, 32'h0);
      apb_rd(32'h01, r);  check("rd_misaligned", r, 32'h0);
      apb_wr(32'h06, 32'hFFFF_FFFF, 4'hF);
      apb_wr(32'h15, 32'hFFFF_FFFF, 4'hF);
      apb_wr(32'h18, 32'hFFFF_FFFF, 4'hF);
      apb_rd(32'h04, r);  check("rb_mtime_hi", r, 32'h0);
      apb_rd(32'h08, r);  check("rb_cmp_lo", r, 32'h10);
      apb_rd(32'h0C, r);  check("rb_cmp_hi", r, 32'h1);
      apb_rd(32'h10, r);  check("rb_ctrl", r, 32'h0);
      apb_rd(32'h14, r);  check("rb_status", r, 32'h1);

      // three wait states, back-to-back access phases
      wsel = 1'b1;
      do_reset();
      apb_wr(32'h08, 32'h0000_0055, 4'hF);
      apb_wr(32'h10, 32'h0000_0200, 4'b0010);
      xfer(1'b0, 32'h08, 32'h0, 4'h0, 1'b1, r);  check("ws3_b2b_0", r, 32'h55);
      xfer(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, r);  check("ws3_b2b_1", r, 32'h200);
      xfer(1'b0, 32'h08, 32'h0, 4'h0, 1'b0, r);  check("ws3_b2b_2", r, 32'h55);
      idle(2);

      // reset during a write's wait states
      paddr = 32'h0C; pdata = 32'hDEAD_BEEF; pwrite = 1'b1; pstb = 4'hF;
      psel = 1'b1; penable = 1'b0; exp_done = 1'b0;
      step();
      penable = 1'b1;
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      step();
      apb_rd(32'h0C, r);  check("rst_abort_cmp_hi", r, 32'h0);
      apb_rd(32'h08, r);  check("rst_clears_cmp_lo", r, 32'h0);

      idle(2);
      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
